wb_initiator: RTL and testbench
===============================

# wb_initiator

Single-outstanding Wishbone B4 pipelined bus initiator for the ECAP5 peripheral fabric. Accepts one read or write command on a valid/ready request port and drives the Wishbone master signals, honouring stall and ack. It returns read data or an error on a one-cycle response strobe. It is the master-side counterpart of the memory-mapped peripherals (e.g. the UART register block) and is used by debug bridges and DMA-style sequencers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed from cycle start to ack before abort; 0 disables timeout.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command present.
- req_ready_o  out  1  command accepted when valid & ready at a rising edge.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  32  byte address.
- req_dat_i  in  32  write data.
- req_sel_i  in  4  byte lane select.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_dat_o  out  32  read data (0 for writes and errors); held until next response.
- rsp_err_o  out  1  timeout abort flag; valid with rsp_valid_o, held like rsp_dat_o.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  bus write data.
- wb_dat_i  in  32  bus read data.
- wb_we_o  out  1  bus write enable.
- wb_sel_o  out  4  bus byte select.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_cyc_o  out  1  cycle.
- wb_stall_i  in  1  responder stall.

## Operation
- The FSM has four states: IDLE, REQUEST, WAIT_ACK and RESPONSE. All outputs are registered or decoded from state only.
- IDLE:
  - req_ready_o=1; cyc/stb=0.
  - On valid & ready, latch adr/dat/we/sel into the wb_* output registers.
  - Clear the timeout counter and go to REQUEST.
- REQUEST:
  - cyc=1, stb=1.
  - If wb_stall_i=0, the strobe is accepted; go to WAIT_ACK.
  - If wb_stall_i=1, stay in REQUEST with address, data and select unchanged.
  - wb_ack_i is ignored in this state.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On wb_ack_i: capture wb_dat_i into rsp_dat_o for a read, or load 0 for a write; set rsp_err_o=0; go to RESPONSE.
- RESPONSE:
  - cyc=0, stb=0, rsp_valid_o=1 for exactly this cycle.
  - Return to IDLE on the next cycle.
- Timeout:
  - The counter, $clog2(TIMEOUT_CYCLES+1) bits wide, increments every cycle in REQUEST or WAIT_ACK.
  - When it equals TIMEOUT_CYCLES-1 and no ack is sampled in that cycle, abort: go to RESPONSE with rsp_err_o=1 and rsp_dat_o=0.
  - If ack and timeout fall in the same cycle while in WAIT_ACK, the ack wins.
- Late acks: an ack arriving in IDLE or RESPONSE is ignored.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, all wb_* outputs 0.
- Reset mid-transaction: cyc/stb are 0 in the cycle after reset is sampled, no response is issued, and the counter clears.

## Timing
- Zero-wait responder (ack registered one cycle after an unstalled strobe):
  - Accept at edge 0.
  - cyc/stb high in cycle 1.
  - ack in cycle 2.
  - rsp_valid_o in cycle 3.
  - req_ready_o high again in cycle 4.
- Throughput: one transaction per 4 cycles, plus stall cycles and ack wait cycles.
- Each stall cycle adds 1 cycle of latency. Each cycle without ack in WAIT_ACK adds 1 cycle.
- wb_stb_o is high for exactly (number of stall cycles + 1) cycles per transaction.
- wb_cyc_o is continuous from REQUEST until the cycle before RESPONSE.

## Test plan
- Read, zero-wait: read adr 0x00000008, responder returns 0xDEADBEEF with ack one cycle after stb → wb_we_o=0, wb_sel_o=0xF, rsp_valid_o in cycle 3 with rsp_dat_o=0xDEADBEEF and rsp_err_o=0.
- Write with stall: write adr 0x0000000C, data 0x55, sel 0x1, wb_stall_i held 3 cycles → stb high 4 cycles with constant adr/dat; rsp_valid_o in cycle 6 with rsp_dat_o=0 and rsp_err_o=0.
- Timeout: TIMEOUT_CYCLES=8, responder never acks → cyc drops after exactly 8 cycles with cyc=1; rsp_err_o=1, rsp_dat_o=0; the next command is accepted.
- Ack on the timeout boundary: TIMEOUT_CYCLES=8, ack arrives in the 8th cycle → rsp_err_o=0 and read data is captured.
- Back-to-back traffic: req_valid_i held high with 3 queued reads → req_ready_o pulses once per 4 cycles; responses arrive in order with the correct data; a spurious ack in IDLE is ignored.
- Reset mid-transaction: assert rst_i during WAIT_ACK → next cycle cyc=0, stb=0, rsp_valid_o=0, req_ready_o=1; no response is ever emitted for the aborted command.

Source files
------------

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator.
// A valid/ready command port starts one bus cycle. The result comes back on a
// one-cycle response strobe, carrying either read data or a timeout abort flag.
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  // A zero TIMEOUT_CYCLES disables the abort; keep a 1-bit counter so that
  // the declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? int'(TIMEOUT_CYCLES) - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2,
    RESPONSE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_hit;
  logic [31:0]      adr_q;
  logic [31:0]      dat_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [31:0]      rsp_dat_q;
  logic             rsp_err_q;

  // The counter holds the number of bus cycles already spent minus one, so
  // hitting TO_LAST marks the final allowed cycle.
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Main FSM: command latch, bus handshake, timeout and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Acks seen here belong to no transaction and are dropped.
          if (req_valid_i) begin
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            we_q    <= req_we_i;
            sel_q   <= req_sel_i;
            cnt_q   <= '0;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          // An ack cannot belong to a strobe that has not been accepted yet.
          cnt_q <= cnt_d;
          if (timeout_hit) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= RESPONSE;
          end else if (!wb_stall_i) begin
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          cnt_q <= cnt_d;
          // The ack is checked first so that it wins over an expiring timer.
          if (wb_ack_i) begin
            rsp_dat_q <= we_q ? 32'h0 : wb_dat_i;
            rsp_err_q <= 1'b0;
            state_q   <= RESPONSE;
          end else if (timeout_hit) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b1;
            state_q   <= RESPONSE;
          end
        end
        RESPONSE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and bus control outputs decode directly from the state register.
  assign req_ready_o = (state_q == IDLE);
  assign wb_cyc_o    = (state_q == REQUEST) || (state_q == WAIT_ACK);
  assign wb_stb_o    = (state_q == REQUEST);
  assign rsp_valid_o = (state_q == RESPONSE);

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator (TIMEOUT_CYCLES = 8). The bench plays the
// responder cycle by cycle: inputs change 1 ns after a rising edge, and
// outputs are checked at that same point.
module tb_wb_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_cyc_o;
  logic        wb_stall_i = 1'b0;

  int total = 0;
  int bad   = 0;

  wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Present one command for a single edge (edge 0 of the transaction).
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
    tick;
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick; tick;
    rst_i = 1'b0;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end total++;
    if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err_o); end total++;
    if (rsp_dat_o !== 32'h0) begin bad++; $display("FAIL reset_rsp_dat got=%h want=0", rsp_dat_o); end total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end total++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h want=0", wb_adr_o, wb_dat_o, wb_sel_o); end total++;
    $display("txn reset done");
  endtask

  task automatic test_read_zero_wait;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    // cycle 1: strobe on the bus
    if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin bad++; $display("FAIL rd_c1_cycstb got=%b want=11", {wb_cyc_o, wb_stb_o}); end total++;
    if (wb_adr_o !== 32'h8) begin bad++; $display("FAIL rd_adr got=%h want=00000008", wb_adr_o); end total++;
    if ({wb_we_o, wb_sel_o} !== 5'b0_1111) begin bad++; $display("FAIL rd_we_sel got=%b want=01111", {wb_we_o, wb_sel_o}); end total++;
    if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rd_c1_ready got=%b want=0", req_ready_o); end total++;
    tick;
    // cycle 2: responder acks
    if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin bad++; $display("FAIL rd_c2_cycstb got=%b want=10", {wb_cyc_o, wb_stb_o}); end total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rd_c2_rsp_valid got=%b want=0", rsp_valid_o); end total++;
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick;
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    // cycle 3: response
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL rd_c3_rsp_valid got=%b want=1", rsp_valid_o); end total++;
    if (rsp_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rsp_dat got=%h want=deadbeef", rsp_dat_o); end total++;
    if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL rd_rsp_err got=%b want=0", rsp_err_o); end total++;
    if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL rd_c3_cyc got=%b want=0", wb_cyc_o); end total++;
    tick;
    // cycle 4: ready again, data held
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rd_c4_ready got=%b want=1", req_ready_o); end total++;
    if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rd_c4_rsp_valid got=%b want=0", rsp_valid_o); end total++;
    if (rsp_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold got=%h want=deadbeef", rsp_dat_o); end total++;
    $display("txn read adr=00000008 dat=%h err=%b", rsp_dat_o, rsp_err_o);
  endtask

  task automatic test_write_stall;
    int stb_cnt;
    stb_cnt = 0;
    wb_stall_i = 1'b1;
    issue(1'b1, 32'h0000_000C, 32'h0000_0055, 4'h1);
    // cycles 1..3 stalled, cycle 4 accepted
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) wb_stall_i = 1'b0;
      if (wb_stb_o === 1'b1) stb_cnt++;
      if ({wb_adr_o, wb_dat_o} !== {32'hC, 32'h55}) begin bad++; $display("FAIL wr_stall_bus c%0d got=%h/%h want=0000000c/00000055", i, wb_adr_o, wb_dat_o); end total++;
      if ({wb_we_o, wb_sel_o} !== 5'b1_0001) begin bad++; $display("FAIL wr_we_sel c%0d got=%b want=10001", i, {wb_we_o, wb_sel_o}); end total++;
      tick;
    end
    // cycle 5: waiting for ack
    if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin bad++; $display("FAIL wr_c5_cycstb got=%b want=10", {wb_cyc_o, wb_stb_o}); end total++;
    if (stb_cnt != 4) begin bad++; $display("FAIL wr_stb_cycles got=%0d want=4", stb_cnt); end total++;
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    tick;
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    // cycle 6: response
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL wr_c6_rsp_valid got=%b want=1", rsp_valid_o); end total++;
    if (rsp_dat_o !== 32'h0) begin bad++; $display("FAIL wr_rsp_dat got=%h want=00000000", rsp_dat_o); end total++;
    if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL wr_rsp_err got=%b want=0", rsp_err_o); end total++;
    $display("txn write adr=0000000c dat=00000055 stalls=3 rsp=%h err=%b", rsp_dat_o, rsp_err_o);
    tick;
  endtask

  task automatic test_ack_boundary;
    issue(1'b0, 32'h0000_0014, 32'h0, 4'hF);
    // cycles 1..7: no ack, bus cycle stays open
    for (int i = 1; i <= 7; i++) begin
      if (wb_cyc_o !== 1'b1) begin bad++; $display("FAIL bnd_cyc c%0d got=%b want=1", i, wb_cyc_o); end total++;
      tick;
    end
    // cycle 8: last allowed cycle, ack arrives
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    tick;
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL bnd_rsp_valid got=%b want=1", rsp_valid_o); end total++;
    if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL bnd_rsp_err got=%b want=0", rsp_err_o); end total++;
    if (rsp_dat_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL bnd_rsp_dat got=%h want=cafef00d", rsp_dat_o); end total++;
    $display("txn read adr=00000014 ack_in_cycle=8 dat=%h err=%b", rsp_dat_o, rsp_err_o);
    tick;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    while (wb_cyc_o === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    if (n != 8) begin bad++; $display("FAIL to_cyc_cycles got=%0d want=8", n); end total++;
    if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL to_rsp_valid got=%b want=1", rsp_valid_o); end total++;
    if (rsp_err_o !== 1'b1) begin bad++; $display("FAIL to_rsp_err got=%b want=1", rsp_err_o); end total++;
    if (rsp_dat_o !== 32'h0) begin bad++; $display("FAIL to_rsp_dat got=%h want=00000000", rsp_dat_o); end total++;
    $display("txn read adr=00000010 timeout after %0d cycles err=%b", n, rsp_err_o);
    tick;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL to_ready_after got=%b want=1", req_ready_o); end total++;
    // next command goes through normally
    issue(1'b0, 32'h0000_0018, 32'h0, 4'hF);
    if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin bad++; $display("FAIL to_next_cycstb got=%b want=11", {wb_cyc_o, wb_stb_o}); end total++;
    tick;
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    tick;
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin bad++; $display("FAIL to_next_rsp got=%b want=10", {rsp_valid_o, rsp_err_o}); end total++;
    if (rsp_dat_o !== 32'h1234_5678) begin bad++; $display("FAIL to_next_dat got=%h want=12345678", rsp_dat_o); end total++;
    $display("txn read adr=00000018 dat=%h err=%b", rsp_dat_o, rsp_err_o);
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] adrs [3];
    logic [31:0] dats [3];
    logic [31:0] prev;
    int phase;
    int t;
    adrs[0] = 32'h20; adrs[1] = 32'h24; adrs[2] = 32'h28;
    dats[0] = 32'h1111_0001; dats[1] = 32'h2222_0002; dats[2] = 32'h3333_0003;
    prev = 32'h1234_5678;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_sel_i = 4'hF; req_dat_i = 32'h0;
    for (int c = 0; c < 12; c++) begin
      phase = c % 4;
      t = c / 4;
      if (phase == 0) begin
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready c%0d got=%b want=1", c, req_ready_o); end total++;
        req_adr_i = adrs[t];
        // spurious ack while idle
        wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_BAD0;
      end else if (phase == 1) begin
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        if ({req_ready_o, wb_stb_o, rsp_valid_o} !== 3'b010) begin bad++; $display("FAIL b2b_req c%0d got=%b want=010", c, {req_ready_o, wb_stb_o, rsp_valid_o}); end total++;
        if (wb_adr_o !== adrs[t]) begin bad++; $display("FAIL b2b_adr c%0d got=%h want=%h", c, wb_adr_o, adrs[t]); end total++;
        if (rsp_dat_o !== prev) begin bad++; $display("FAIL b2b_idle_ack c%0d got=%h want=%h", c, rsp_dat_o, prev); end total++;
      end else if (phase == 2) begin
        if ({req_ready_o, wb_cyc_o, wb_stb_o} !== 3'b010) begin bad++; $display("FAIL b2b_wait c%0d got=%b want=010", c, {req_ready_o, wb_cyc_o, wb_stb_o}); end total++;
        wb_ack_i = 1'b1; wb_dat_i = dats[t];
      end else begin
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b010) begin bad++; $display("FAIL b2b_rsp c%0d got=%b want=010", c, {req_ready_o, rsp_valid_o, rsp_err_o}); end total++;
        if (rsp_dat_o !== dats[t]) begin bad++; $display("FAIL b2b_dat c%0d got=%h want=%h", c, rsp_dat_o, dats[t]); end total++;
        $display("txn b2b read adr=%h dat=%h", adrs[t], rsp_dat_o);
        prev = dats[t];
        if (t == 2) req_valid_i = 1'b0;
      end
      tick;
    end
    if ({req_ready_o, wb_cyc_o} !== 2'b10) begin bad++; $display("FAIL b2b_end got=%b want=10", {req_ready_o, wb_cyc_o}); end total++;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    issue(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    tick;
    if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin bad++; $display("FAIL rstm_wait got=%b want=10", {wb_cyc_o, wb_stb_o}); end total++;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    if ({wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin bad++; $display("FAIL rstm_after got=%b want=0001", {wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o}); end total++;
    if (rsp_dat_o !== 32'h0) begin bad++; $display("FAIL rstm_rsp_dat got=%h want=00000000", rsp_dat_o); end total++;
    // a late ack for the aborted command must not produce a response
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o === 1'b1 || wb_cyc_o === 1'b1) seen++;
      tick;
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    end
    if (seen != 0) begin bad++; $display("FAIL rstm_no_rsp got=%0d want=0", seen); end total++;
    $display("txn read adr=00000030 aborted by reset");
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_stall;
    test_ack_boundary;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
